// File: rtl/aes_key_ctx.sv
// aes_key_ctx
//   Multi-context AES round-key store with a timed key streamer.
//   NSLOT independent contexts each hold NR+1 128-bit round keys. Keys are
//   loaded in WR_W-bit chunks. A per-chunk written bitmap tracks when a
//   context is complete. A streamer then presents round keys 0..NR to the
//   cipher core, holding each one for ROUND_CYC cycles.
//
// Ports
//   clk           rising-edge clock
//   kill          synchronous active-high reset
//   en_wr         chunk write strobe
//   wr_slot       context targeted by en_wr / slot_clr
//   addr_wr       chunk address (word = addr_wr/CH, chunk = addr_wr%CH)
//   key_round_wr  chunk data (chunk 0 = bits [WR_W-1:0] of the word)
//   slot_clr      invalidate context wr_slot
//   rd_start      start streaming context rd_slot
//   rd_slot       context to stream
//   key_round     current round key (held while key_valid=0)
//   key_valid     key_round is a live round key
//   key_idx       round index of key_round
//   key_last      round NR is being presented
//   rd_busy       streamer is active (FETCH or STREAM)
//   slot_ready    per-context fully-loaded flags
//   wr_err        one-cycle pulse: write or clear rejected
//   rd_err        one-cycle pulse: rd_start rejected
//
// FSM states
//   state     | meaning
//   ST_IDLE   | waiting for an accepted rd_start
//   ST_FETCH  | loading round key 0 into the output register
//   ST_STREAM | presenting round keys, ROUND_CYC cycles each
module aes_key_ctx #(
  parameter int NR        = 10,
  parameter int NSLOT     = 4,
  parameter int WR_W      = 64,
  parameter int ROUND_CYC = 3
) (
  input  logic                                      clk,
  input  logic                                      kill,
  input  logic                                      en_wr,
  input  logic [$clog2(NSLOT)-1:0]                  wr_slot,
  input  logic [$clog2((NR+1)*(128/WR_W))-1:0]      addr_wr,
  input  logic [WR_W-1:0]                           key_round_wr,
  input  logic                                      slot_clr,
  input  logic                                      rd_start,
  input  logic [$clog2(NSLOT)-1:0]                  rd_slot,
  output logic [127:0]                              key_round,
  output logic                                      key_valid,
  output logic [3:0]                                key_idx,
  output logic                                      key_last,
  output logic                                      rd_busy,
  output logic [NSLOT-1:0]                          slot_ready,
  output logic                                      wr_err,
  output logic                                      rd_err
);

  localparam int CH = 128 / WR_W;
  localparam int NW = (NR + 1) * CH;
  localparam int AW = $clog2(NW);
  localparam int SW = $clog2(NSLOT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Chunk storage, flat chunk index == addr_wr since word*CH+chunk == addr_wr
  logic [WR_W-1:0] mem_q [NSLOT][NW];
  logic [NW-1:0]   bitmap_q [NSLOT];

  logic [SW-1:0]   cur_slot_q;
  logic [3:0]      round_q;
  logic [1:0]      cnt_q;
  logic [127:0]    key_q;
  logic            wr_err_q;
  logic            rd_err_q;

  logic [2**SW-1:0] slot_exists;
  logic             start_ok;
  logic             rd_err_d;
  logic             load_key;
  logic [3:0]       ld_round;
  logic [AW-1:0]    ld_base;
  logic [127:0]     rd_word;

  logic             busy_hit;
  logic             addr_ok;
  logic             clr_do;
  logic             wr_do;
  logic             wr_err_d;

  // Slot indices beyond NSLOT-1 (non power-of-two NSLOT) are treated as absent
  always_comb begin
    slot_exists = '0;
    slot_exists[NSLOT-1:0] = '1;
  end

  always_comb begin
    slot_ready = '0;
    for (int s = 0; s < NSLOT; s++) begin
      slot_ready[s] = &bitmap_q[s];
    end
  end

  // --------------------------------------------------------------------
  // Streamer FSM: next state and control
  // --------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    rd_err_d = 1'b0;
    load_key = 1'b0;
    ld_round = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          if (slot_exists[rd_slot] && slot_ready[rd_slot]) begin
            start_ok = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            rd_err_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        load_key = 1'b1;
        state_d  = ST_STREAM;
      end
      ST_STREAM: begin
        if (cnt_q == 2'd0) begin
          if (round_q == 4'(NR)) begin
            state_d = ST_IDLE;
          end else begin
            load_key = 1'b1;
            ld_round = round_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rd_start && (state_q != ST_IDLE)) begin
      rd_err_d = 1'b1;
    end
  end

  // Assemble the 128-bit word for the round about to be presented
  always_comb begin
    ld_base = AW'(ld_round) * AW'(CH);
    rd_word = '0;
    for (int c = 0; c < CH; c++) begin
      rd_word[c*WR_W +: WR_W] = mem_q[cur_slot_q][ld_base + AW'(c)];
    end
  end

  // --------------------------------------------------------------------
  // Write / clear arbitration
  // --------------------------------------------------------------------
  always_comb begin
    busy_hit = rd_busy && (wr_slot == cur_slot_q);
    addr_ok  = addr_wr < AW'(NW);
    clr_do   = slot_clr && slot_exists[wr_slot] && !busy_hit;
    // slot_clr shares wr_slot, so a clear always overrides a same-cycle write
    wr_do    = en_wr && !slot_clr && slot_exists[wr_slot] && !busy_hit && addr_ok;
    wr_err_d = (slot_clr && !clr_do) || (en_wr && !slot_clr && !wr_do);
  end

  // --------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (kill) begin
      state_q    <= ST_IDLE;
      cur_slot_q <= '0;
      round_q    <= '0;
      cnt_q      <= '0;
      key_q      <= '0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      for (int s = 0; s < NSLOT; s++) begin
        bitmap_q[s] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
      if (start_ok) begin
        cur_slot_q <= rd_slot;
      end
      if (load_key) begin
        key_q   <= rd_word;
        round_q <= ld_round;
        cnt_q   <= 2'(ROUND_CYC - 1);
      end else if ((state_q == ST_STREAM) && (cnt_q != 2'd0)) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (clr_do) begin
        bitmap_q[wr_slot] <= '0;
      end else if (wr_do) begin
        bitmap_q[wr_slot][addr_wr] <= 1'b1;
      end
    end
  end

  // Key storage is not reset; the bitmap alone decides validity
  always_ff @(posedge clk) begin
    if (!kill && wr_do) begin
      mem_q[wr_slot][addr_wr] <= key_round_wr;
    end
  end

  assign key_round = key_q;
  assign key_idx   = round_q;
  assign key_valid = (state_q == ST_STREAM);
  assign key_last  = (state_q == ST_STREAM) && (round_q == 4'(NR));
  assign rd_busy   = (state_q != ST_IDLE);
  assign wr_err    = wr_err_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_aes_key_ctx.sv
// Testbench for aes_key_ctx: scoreboard of expected key beats, consumed by
// per-DUT monitors whenever key_valid is high, plus directed cycle checks.
module tb_aes_key_ctx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic kill;

  // DUT 0: default parameters
  logic         en_wr, slot_clr, rd_start;
  logic [1:0]   wr_slot, rd_slot;
  logic [4:0]   addr_wr;
  logic [63:0]  key_round_wr;
  logic [127:0] key_round;
  logic         key_valid, key_last, rd_busy, wr_err, rd_err;
  logic [3:0]   key_idx, slot_ready;

  // DUT 1: NR=14, WR_W=32, ROUND_CYC=1
  logic         d1_en_wr, d1_slot_clr, d1_rd_start;
  logic [1:0]   d1_wr_slot, d1_rd_slot;
  logic [5:0]   d1_addr_wr;
  logic [31:0]  d1_key_round_wr;
  logic [127:0] d1_key_round;
  logic         d1_key_valid, d1_key_last, d1_rd_busy, d1_wr_err, d1_rd_err;
  logic [3:0]   d1_key_idx, d1_slot_ready;

  aes_key_ctx dut0 (
    .clk(clk), .kill(kill), .en_wr(en_wr), .wr_slot(wr_slot), .addr_wr(addr_wr),
    .key_round_wr(key_round_wr), .slot_clr(slot_clr), .rd_start(rd_start),
    .rd_slot(rd_slot), .key_round(key_round), .key_valid(key_valid),
    .key_idx(key_idx), .key_last(key_last), .rd_busy(rd_busy),
    .slot_ready(slot_ready), .wr_err(wr_err), .rd_err(rd_err)
  );

  aes_key_ctx #(.NR(14), .NSLOT(4), .WR_W(32), .ROUND_CYC(1)) dut1 (
    .clk(clk), .kill(kill), .en_wr(d1_en_wr), .wr_slot(d1_wr_slot),
    .addr_wr(d1_addr_wr), .key_round_wr(d1_key_round_wr), .slot_clr(d1_slot_clr),
    .rd_start(d1_rd_start), .rd_slot(d1_rd_slot), .key_round(d1_key_round),
    .key_valid(d1_key_valid), .key_idx(d1_key_idx), .key_last(d1_key_last),
    .rd_busy(d1_rd_busy), .slot_ready(d1_slot_ready), .wr_err(d1_wr_err),
    .rd_err(d1_rd_err)
  );

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic         last;
  } beat_t;

  beat_t sb0[$];
  beat_t sb1[$];
  beat_t b0, b1;

  int n_chk = 0;
  int n_pass = 0;
  int exp_wr_err0 = 0, seen_wr_err0 = 0;
  int exp_rd_err0 = 0, seen_rd_err0 = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [127:0] kv(input int s, input int r);
    logic [7:0] a, b;
    a = 8'(s);
    b = 8'(r);
    return {a, b, 16'h1111, a, b, 16'h2222, a, b, 16'h3333, a, b, 16'h4444};
  endfunction

  // Monitors: pop one expected beat per valid cycle
  always @(negedge clk) begin
    if (wr_err) seen_wr_err0++;
    if (rd_err) seen_rd_err0++;
    if (key_valid) begin
      if (sb0.size() == 0) begin
        n_chk++;
        $display("FAIL beat0: key_valid=1 idx=%0d but no beat expected", key_idx);
      end else begin
        b0 = sb0.pop_front();
        chk("key_round0", key_round, b0.key);
        chk("key_idx0", 128'(key_idx), 128'(b0.idx));
        chk("key_last0", 128'(key_last), 128'(b0.last));
      end
    end
  end

  always @(negedge clk) begin
    if (d1_key_valid) begin
      if (sb1.size() == 0) begin
        n_chk++;
        $display("FAIL beat1: key_valid=1 idx=%0d but no beat expected", d1_key_idx);
      end else begin
        b1 = sb1.pop_front();
        chk("key_round1", d1_key_round, b1.key);
        chk("key_idx1", 128'(d1_key_idx), 128'(b1.idx));
        chk("key_last1", 128'(d1_key_last), 128'(b1.last));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input int s, input int a, input logic [63:0] d);
    en_wr = 1'b1; wr_slot = 2'(s); addr_wr = 5'(a); key_round_wr = d;
    step();
    en_wr = 1'b0;
  endtask

  task automatic load0(input int s, input int n);
    logic [127:0] w;
    for (int a = 0; a < n; a++) begin
      w = kv(s, a / 2);
      wr0(s, a, w[(a % 2)*64 +: 64]);
    end
  endtask

  task automatic wr1(input int s, input int a, input logic [31:0] d);
    d1_en_wr = 1'b1; d1_wr_slot = 2'(s); d1_addr_wr = 6'(a); d1_key_round_wr = d;
    step();
    d1_en_wr = 1'b0;
  endtask

  // mode 0: plain, mode 1: interfering traffic, mode 2: kill in round 5
  task automatic stream0(input int s, input int mode);
    beat_t e;
    logic [127:0] w3;
    w3 = kv(3, 10);
    rd_start = 1'b1; rd_slot = 2'(s);
    for (int r = 0; r <= 10; r++) begin
      for (int c = 0; c < 3; c++) begin
        e.key = kv(s, r); e.idx = 4'(r); e.last = (r == 10);
        sb0.push_back(e);
      end
    end
    @(negedge clk);
    chk("start_busy0", 128'(rd_busy), 128'(0));
    step();
    rd_start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      en_wr = 1'b0; slot_clr = 1'b0; rd_start = 1'b0;
      if (mode == 1) begin
        case (k)
          3: begin en_wr = 1'b1; wr_slot = 2'd1; addr_wr = 5'd20;
                   key_round_wr = 64'hDEAD_BEEF_0BAD_F00D; exp_wr_err0++; end
          6: begin slot_clr = 1'b1; wr_slot = 2'd1; exp_wr_err0++; end
          9: begin en_wr = 1'b1; wr_slot = 2'd3; addr_wr = 5'd21;
                   key_round_wr = w3[127:64]; end
          12: begin rd_start = 1'b1; rd_slot = 2'd3; exp_rd_err0++; end
          default: ;
        endcase
      end
      if (mode == 2 && k == 17) kill = 1'b1;
      @(negedge clk);
      chk($sformatf("valid0_k%0d", k), 128'(key_valid), 128'(k >= 2));
      chk($sformatf("busy0_k%0d", k), 128'(rd_busy), 128'(1));
      chk($sformatf("last0_k%0d", k), 128'(key_last), 128'(k >= 32));
      if (mode == 1) begin
        chk($sformatf("wr_err0_k%0d", k), 128'(wr_err), 128'(k == 4 || k == 7));
        chk($sformatf("rd_err0_k%0d", k), 128'(rd_err), 128'(k == 13));
        chk($sformatf("ready0_k%0d", k), 128'(slot_ready),
            128'((k >= 10) ? 4'b1010 : 4'b0010));
      end
      step();
      if (mode == 2 && k == 17) begin
        sb0.delete();
        @(negedge clk);
        chk("kill_valid0", 128'(key_valid), 128'(0));
        chk("kill_busy0", 128'(rd_busy), 128'(0));
        chk("kill_ready0", 128'(slot_ready), 128'(0));
        chk("kill_key0", key_round, 128'(0));
        step();
        kill = 1'b0;
        break;
      end
    end
    en_wr = 1'b0; slot_clr = 1'b0; rd_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] w;
    beat_t e;
    kill = 1'b1;
    en_wr = 1'b0; slot_clr = 1'b0; rd_start = 1'b0;
    wr_slot = '0; rd_slot = '0; addr_wr = '0; key_round_wr = '0;
    d1_en_wr = 1'b0; d1_slot_clr = 1'b0; d1_rd_start = 1'b0;
    d1_wr_slot = '0; d1_rd_slot = '0; d1_addr_wr = '0; d1_key_round_wr = '0;
    step(); step();
    @(negedge clk);
    chk("rst_valid", 128'(key_valid), 128'(0));
    chk("rst_busy", 128'(rd_busy), 128'(0));
    chk("rst_last", 128'(key_last), 128'(0));
    chk("rst_idx", 128'(key_idx), 128'(0));
    chk("rst_key", key_round, 128'(0));
    chk("rst_ready", 128'(slot_ready), 128'(0));
    chk("rst_errs", 128'({wr_err, rd_err}), 128'(0));
    step();
    kill = 1'b0;

    // 21 of 22 chunks: not ready; the 22nd completes slot 1
    load0(1, 21);
    @(negedge clk);
    chk("ready_21", 128'(slot_ready), 128'(4'b0000));
    step();
    w = kv(1, 10);
    wr0(1, 21, w[127:64]);
    @(negedge clk);
    chk("ready_22", 128'(slot_ready), 128'(4'b0010));
    step();

    // rd_start on unloaded slot 2
    rd_start = 1'b1; rd_slot = 2'd2; exp_rd_err0++;
    step();
    rd_start = 1'b0;
    @(negedge clk);
    chk("rderr_pulse", 128'(rd_err), 128'(1));
    chk("rderr_busy", 128'(rd_busy), 128'(0));
    step();
    @(negedge clk);
    chk("rderr_clear", 128'(rd_err), 128'(0));
    chk("rderr_busy2", 128'(rd_busy), 128'(0));
    step();

    // out-of-range word index
    exp_wr_err0++;
    wr0(0, 22, 64'h1234);
    @(negedge clk);
    chk("wrerr_addr", 128'(wr_err), 128'(1));
    chk("wrerr_ready", 128'(slot_ready), 128'(4'b0010));
    step();

    load0(3, 21);
    load0(0, 22);
    @(negedge clk);
    chk("ready_s0", 128'(slot_ready), 128'(4'b0011));
    step();

    // clear and write to slot 0 in the same cycle
    slot_clr = 1'b1; en_wr = 1'b1; wr_slot = 2'd0; addr_wr = 5'd0; key_round_wr = '1;
    step();
    slot_clr = 1'b0; en_wr = 1'b0;
    @(negedge clk);
    chk("clr_ready", 128'(slot_ready), 128'(4'b0010));
    chk("clr_no_err", 128'(wr_err), 128'(0));
    step();

    stream0(1, 1);
    stream0(3, 0);
    stream0(1, 2);

    // after kill every slot needs a reload
    rd_start = 1'b1; rd_slot = 2'd1; exp_rd_err0++;
    step();
    rd_start = 1'b0;
    @(negedge clk);
    chk("postkill_rderr", 128'(rd_err), 128'(1));
    chk("postkill_busy", 128'(rd_busy), 128'(0));
    step();

    // DUT 1: 60 chunks per slot, 15 single-cycle rounds
    for (int a = 0; a < 59; a++) begin
      w = kv(2, a / 4);
      wr1(2, a, w[(a % 4)*32 +: 32]);
    end
    @(negedge clk);
    chk("d1_ready_59", 128'(d1_slot_ready), 128'(4'b0000));
    step();
    w = kv(2, 14);
    wr1(2, 59, w[127:96]);
    @(negedge clk);
    chk("d1_ready_60", 128'(d1_slot_ready), 128'(4'b0100));
    step();
    d1_rd_start = 1'b1; d1_rd_slot = 2'd2;
    for (int r = 0; r <= 14; r++) begin
      e.key = kv(2, r); e.idx = 4'(r); e.last = (r == 14);
      sb1.push_back(e);
    end
    step();
    d1_rd_start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk($sformatf("d1_valid_k%0d", k), 128'(d1_key_valid), 128'(k >= 2 && k <= 16));
      chk($sformatf("d1_busy_k%0d", k), 128'(d1_rd_busy), 128'(k <= 16));
      step();
    end

    chk("sb0_drained", 128'(sb0.size()), 128'(0));
    chk("sb1_drained", 128'(sb1.size()), 128'(0));
    chk("wr_err_count0", 128'(seen_wr_err0), 128'(exp_wr_err0));
    chk("rd_err_count0", 128'(seen_rd_err0), 128'(exp_rd_err0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
